// File: rtl/seg7_pkg.sv
// Shared types and segment constants for seven-segment capture/decode.
// Provides the FSM state enum, the hex pattern table and a pure decode function.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOCKED
  } state_t;

  localparam logic [6:0] SEG7_0     = 7'h3F;
  localparam logic [6:0] SEG7_1     = 7'h06;
  localparam logic [6:0] SEG7_2     = 7'h5B;
  localparam logic [6:0] SEG7_3     = 7'h4F;
  localparam logic [6:0] SEG7_4     = 7'h66;
  localparam logic [6:0] SEG7_5     = 7'h6D;
  localparam logic [6:0] SEG7_6     = 7'h7D;
  localparam logic [6:0] SEG7_7     = 7'h07;
  localparam logic [6:0] SEG7_8     = 7'h7F;
  localparam logic [6:0] SEG7_9     = 7'h6F;
  localparam logic [6:0] SEG7_A     = 7'h77;
  localparam logic [6:0] SEG7_B     = 7'h7C;
  localparam logic [6:0] SEG7_C     = 7'h39;
  localparam logic [6:0] SEG7_D     = 7'h5E;
  localparam logic [6:0] SEG7_E     = 7'h79;
  localparam logic [6:0] SEG7_F     = 7'h71;
  localparam logic [6:0] SEG7_BLANK = 7'h00;

  // Returns {valid, digit}; digit is 0 when the pattern is not a hex glyph.
  function automatic logic [4:0] seg7_decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'b0_0000;
    case (p)
      SEG7_0:  r = {1'b1, 4'h0};
      SEG7_1:  r = {1'b1, 4'h1};
      SEG7_2:  r = {1'b1, 4'h2};
      SEG7_3:  r = {1'b1, 4'h3};
      SEG7_4:  r = {1'b1, 4'h4};
      SEG7_5:  r = {1'b1, 4'h5};
      SEG7_6:  r = {1'b1, 4'h6};
      SEG7_7:  r = {1'b1, 4'h7};
      SEG7_8:  r = {1'b1, 4'h8};
      SEG7_9:  r = {1'b1, 4'h9};
      SEG7_A:  r = {1'b1, 4'hA};
      SEG7_B:  r = {1'b1, 4'hB};
      SEG7_C:  r = {1'b1, 4'hC};
      SEG7_D:  r = {1'b1, 4'hD};
      SEG7_E:  r = {1'b1, 4'hE};
      SEG7_F:  r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern decoder (pattern -> valid, blank, digit).
// Ports: pattern[6:0] in; valid, blank, digit[3:0] out.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       valid,
  output logic       blank,
  output logic [3:0] digit
);

  assign {valid, digit} = seg7_decode(pattern);
  assign blank = (pattern == SEG7_BLANK);

endmodule

// File: rtl/seg7_capture_decoder.sv
// Captures a seven-segment bus, waits for STABLE_CYCLES stable samples, decodes.
// Ports: clk, rst (async high), seg_in[6:0]; digit[3:0], digit_valid,
// pattern_err, blank, change_count[CNT_W-1:0].
// Macro SEG7_CAPTURE_ACTIVE_LOW_EN: treat seg_in as active-low (common anode).
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             pattern_err,
  output logic             blank,
  output logic [CNT_W-1:0] change_count
);

  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

`ifdef SEG7_CAPTURE_ACTIVE_LOW_EN
  // Flops hold the raw bus; all-off on a common-anode panel is 7'h7F.
  localparam logic [6:0] SYNC_RST = 7'h7F;
`else
  localparam logic [6:0] SYNC_RST = 7'h00;
`endif

  logic [6:0] sync1;
  logic [6:0] sync2;
  logic [6:0] seg_s;

  state_t     state;
  state_t     state_d;
  logic [6:0] cand;
  logic [6:0] cand_d;
  logic [7:0] cnt;
  logic [7:0] cnt_d;
  logic       lock;

  logic       dec_valid;
  logic       dec_blank;
  logic [3:0] dec_digit;

  logic       lock_valid;
  logic       lock_err;
  logic       lock_blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= SYNC_RST;
      sync2 <= SYNC_RST;
    end else begin
      sync1 <= seg_in;
      sync2 <= sync1;
    end
  end

`ifdef SEG7_CAPTURE_ACTIVE_LOW_EN
  assign seg_s = ~sync2;
`else
  assign seg_s = sync2;
`endif

  seg7_pattern_decode u_dec (
    .pattern (cand),
    .valid   (dec_valid),
    .blank   (dec_blank),
    .digit   (dec_digit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cand  <= 7'h00;
      cnt   <= 8'd0;
    end else begin
      state <= state_d;
      cand  <= cand_d;
      cnt   <= cnt_d;
    end
  end

  // A change on seg_s always wins over a lock in the same cycle.
  always_comb begin
    state_d = state;
    cand_d  = cand;
    cnt_d   = cnt;
    lock    = 1'b0;
    if (seg_s != cand) begin
      cand_d  = seg_s;
      cnt_d   = 8'd0;
      state_d = SETTLE;
    end else if (state == SETTLE && cnt == LAST) begin
      lock    = 1'b1;
      state_d = dec_blank ? IDLE : LOCKED;
    end else if (state == SETTLE) begin
      cnt_d = cnt + 8'd1;
    end
  end

  always_comb begin
    lock_valid = lock && dec_valid;
    lock_err   = lock && !dec_valid && !dec_blank;
    lock_blank = lock && dec_blank;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit        <= 4'h0;
      digit_valid  <= 1'b0;
      pattern_err  <= 1'b0;
      blank        <= 1'b1;
      change_count <= '0;
    end else begin
      digit_valid <= lock_valid;
      pattern_err <= lock_err;
      if (lock_valid) begin
        digit        <= dec_digit;
        blank        <= 1'b0;
        change_count <= change_count + 1'b1;
      end
      if (lock_blank) begin
        blank <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Scoreboard bench for seg7_capture_decoder.
// Predicted lock events are queued by the driver and matched against strobes.
module tb_seg7_capture_decoder;

  localparam int S = 4;

  logic       clk;
  logic       rst;
  logic [6:0] seg_in;
  logic [3:0] digit;
  logic       digit_valid;
  logic       pattern_err;
  logic       blank;
  logic [7:0] change_count;

  seg7_capture_decoder #(
    .STABLE_CYCLES (S),
    .CNT_W         (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .seg_in       (seg_in),
    .digit        (digit),
    .digit_valid  (digit_valid),
    .pattern_err  (pattern_err),
    .blank        (blank),
    .change_count (change_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    int         edge_n;
    logic [3:0] dig;
    logic [7:0] cnt;
  } ev_t;

  ev_t q[$];
  ev_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;
  int ecnt;

  logic [6:0] cur_v;
  int         run_start;
  int         run_len;
  logic [3:0] exp_digit;
  logic [7:0] exp_count;
  logic       exp_blank;

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                           7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                           7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] phys(input logic [6:0] v);
`ifdef SEG7_CAPTURE_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (digit_valid && pattern_err) check("both_strobes", 1, 0);
      if (q.size() != 0 && ecnt > q[0].edge_n) begin
        check("missed_edge", ecnt, q[0].edge_n);
        void'(q.pop_front());
      end
      if (digit_valid || pattern_err) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", {digit_valid, pattern_err}, 0);
        end else begin
          mon_e = q.pop_front();
          check("strobe_kind", pattern_err, mon_e.err);
          check("strobe_edge", ecnt, mon_e.edge_n);
          check("strobe_digit", digit, mon_e.dig);
          check("strobe_count", change_count, mon_e.cnt);
        end
      end
    end
  end

  // One sample per call; edge_n is the posedge that will sample v.
  task automatic model(input logic [6:0] v, input int edge_n);
    ev_t e;
    int  hit;
    if (v != cur_v) begin
      cur_v     = v;
      run_start = edge_n;
      run_len   = 1;
    end else begin
      run_len++;
    end
    if (run_len == S + 1) begin
      hit = -1;
      for (int i = 0; i < 16; i++) if (tbl[i] == v) hit = i;
      if (v == 7'h00) begin
        exp_blank = 1'b1;
      end else if (hit >= 0) begin
        exp_digit = 4'(hit);
        exp_count = exp_count + 8'd1;
        exp_blank = 1'b0;
        e.err = 1'b0;
        e.edge_n = run_start + S + 2;
        e.dig = exp_digit;
        e.cnt = exp_count;
        q.push_back(e);
      end else begin
        e.err = 1'b1;
        e.edge_n = run_start + S + 2;
        e.dig = exp_digit;
        e.cnt = exp_count;
        q.push_back(e);
      end
    end
  endtask

  task automatic hold(input logic [6:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      seg_in = phys(v);
      model(v, ecnt + 1);
      @(negedge clk);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cur_v     = 7'h00;
    run_start = 0;
    run_len   = 1000;
    exp_digit = 4'h0;
    exp_count = 8'd0;
    exp_blank = 1'b1;
  endtask

  task automatic check_levels(input string tag);
    check({tag, "_digit"}, digit, exp_digit);
    check({tag, "_count"}, change_count, exp_count);
    check({tag, "_blank"}, blank, exp_blank);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    seg_in = phys(7'h00);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_digit", digit, 0);
    check("rst_valid", digit_valid, 0);
    check("rst_err", pattern_err, 0);
    check("rst_blank", blank, 1);
    check("rst_count", change_count, 0);
    rst = 1'b0;

    hold(7'h00, 10);
    check_levels("blank_after_rst");

    hold(7'h5B, 10);
    check_levels("lock_2");

    hold(7'h3F, 10);
    hold(7'h06, 2);
    hold(7'h3F, 10);
    check_levels("glitch_relock");

    hold(7'h55, 10);
    check_levels("invalid");

    for (int i = 0; i < 25; i++) begin
      hold(7'h7F, 1);
      hold(7'h6F, 1);
    end
    hold(7'h6F, 10);
    check_levels("toggle");

    hold(7'h4F, S);
    hold(7'h66, 10);
    check_levels("short_run");

    hold(7'h00, 10);
    check_levels("blank_lock");

    hold(7'h7C, 10);
    check_levels("lock_b");

    hold(7'h6D, S + 1);
    hold(7'h07, 10);
    check_levels("min_run");

    hold(7'h66, 5);
    rst = 1'b1;
    #1;
    check("async_digit", digit, 0);
    check("async_valid", digit_valid, 0);
    check("async_blank", blank, 1);
    check("async_count", change_count, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    hold(7'h66, 10);
    check_levels("post_rst_4");

    hold(7'h71, 10);
    check_levels("lock_f");

    check("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
